// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
//   state_e       : stall sequencer states (RUN=0, MULDIV=1)
//   MEMREAD_NONE  : MemRead encoding meaning "not a load"
//   REG_ZERO      : architectural register $0 (hardwired zero, never a hazard)
//   is_load_use() : load-use hazard test between the EX and ID instructions
package mips_pipe_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } state_e;

    localparam logic [1:0] MEMREAD_NONE = 2'b00;
    localparam logic [4:0] REG_ZERO     = 5'd0;

    // A load in EX whose destination is read by the ID instruction must be
    // separated by one bubble. Writes to $0 are discarded, so they never stall.
    function automatic logic is_load_use(
        input logic [1:0] ex_mem_read,
        input logic       ex_reg_write,
        input logic [4:0] ex_dest_reg,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return (ex_mem_read != MEMREAD_NONE) && ex_reg_write &&
               (ex_dest_reg != REG_ZERO) &&
               ((ex_dest_reg == id_rs) || (id_uses_rt && (ex_dest_reg == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   srst  : synchronous clear (wins over inc)
//   inc   : count enable; holds at all-ones once reached
//   count : current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline.
// Inputs : Clk, Reset (sync, active high), ID register fields (IDRs, IDRt,
//          IDUsesRt, IDIsMulDiv), BranchTaken, EX-stage controls
//          (EXMemRead, EXRegWrite, EXDestReg).
// Outputs: PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush (Mealy),
//          MulDivBusy, and saturating StallCycles / FlushCount counters.
module hazard_stall_controller
    import mips_pipe_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       IDRs,
    input  logic [4:0]       IDRt,
    input  logic             IDUsesRt,
    input  logic             IDIsMulDiv,
    input  logic             BranchTaken,
    input  logic [1:0]       EXMemRead,
    input  logic             EXRegWrite,
    input  logic [4:0]       EXDestReg,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXWrite,
    output logic             IDEXFlush,
    output logic             MulDivBusy,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int                  CNT_BITS = $clog2(MULDIV_CYCLES);
    // The first EX cycle of the mult/div happens in RUN, so the hold phase
    // lasts MULDIV_CYCLES-1 cycles: load MULDIV_CYCLES-2 and exit at zero.
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MULDIV_CYCLES - 2);

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                load_use;

    always_comb begin
        load_use = is_load_use(EXMemRead, EXRegWrite, EXDestReg,
                               IDRs, IDRt, IDUsesRt);
    end

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        MulDivBusy = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;

        if (Reset) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
            IFIDFlush = 1'b1;
            state_d   = RUN;
            cnt_d     = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (load_use) begin
                        // Freeze IF/ID and insert one bubble; the branch or
                        // mult/div in ID is re-evaluated next cycle.
                        PCWrite   = 1'b0;
                        IFIDWrite = 1'b0;
                        IDEXFlush = 1'b1;
                    end else if (IDIsMulDiv) begin
                        IFIDFlush = BranchTaken;
                        state_d   = MULDIV;
                        cnt_d     = CNT_LOAD;
                    end else if (BranchTaken) begin
                        IFIDFlush = 1'b1;
                    end
                end
                MULDIV: begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXWrite  = 1'b0;
                    MulDivBusy = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (Clk),
        .srst  (Reset),
        .inc   (~PCWrite),
        .count (StallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (Clk),
        .srst  (Reset),
        .inc   (IFIDFlush),
        .count (FlushCount)
    );

endmodule
